// File: rtl/wb_sevenseg_pkg.sv
// Shared constants for the Wishbone seven-segment controller:
// register offsets, CTRL field layout and reset values, and the hex segment table.
package wb_sevenseg_pkg;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_CTRL   = 2'd1;
  localparam logic [1:0] ADR_DPMASK = 2'd2;
  localparam logic [1:0] ADR_BLANK  = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BRIGHT_LSB = 8;

  localparam logic       EN_RST     = 1'b1;
  localparam logic [7:0] BRIGHT_RST = 8'hff;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module seg7_decode
  import wb_sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/wb_sevenseg_ctrl.sv
// Wishbone-controlled multiplexed seven-segment driver with per-digit
// blanking, decimal points and PWM brightness.
module wb_sevenseg_ctrl
  import wb_sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_W      = 15
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_rst,
  input  logic [3:0]            i_wb_adr,
  input  logic [31:0]           i_wb_dat,
  input  logic [3:0]            i_wb_sel,
  input  logic                  i_wb_we,
  input  logic                  i_wb_cyc,
  input  logic                  i_wb_stb,
  output logic [31:0]           o_wb_rdt,
  output logic                  o_wb_ack,
  output logic [6:0]            o_ca,
  output logic                  o_dp,
  output logic [NUM_DIGITS-1:0] o_an
);

  localparam logic [7:0] DIG_MASK = 8'((1 << NUM_DIGITS) - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [31:0]      data;
  logic             en;
  logic [7:0]       bright;
  logic [7:0]       dpmask;
  logic [7:0]       blank;
  logic [DIV_W-1:0] pre;
  logic [2:0]       idx;
  logic [7:0]       level;
  logic [3:0]       nibble;
  logic [6:0]       seg;
  logic             lit;
  logic             req;
  logic             wr;
  logic [31:0]      rd_mux;
  logic             unused_adr;

  assign unused_adr = ^i_wb_adr[1:0];
  assign req = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr  = req & i_wb_we;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      data   <= '0;
      en     <= EN_RST;
      bright <= BRIGHT_RST;
      dpmask <= '0;
      blank  <= '0;
    end else if (wr) begin
      case (i_wb_adr[3:2])
        ADR_DATA: begin
          for (int b = 0; b < 4; b++)
            if (i_wb_sel[b]) data[8*b +: 8] <= i_wb_dat[8*b +: 8];
        end
        ADR_CTRL: begin
          if (i_wb_sel[0]) en     <= i_wb_dat[CTRL_EN_BIT];
          if (i_wb_sel[1]) bright <= i_wb_dat[CTRL_BRIGHT_LSB +: 8];
        end
        ADR_DPMASK: if (i_wb_sel[0]) dpmask <= i_wb_dat[7:0] & DIG_MASK;
        default:    if (i_wb_sel[0]) blank  <= i_wb_dat[7:0] & DIG_MASK;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (i_wb_adr[3:2])
      ADR_DATA:   rd_mux = data;
      ADR_CTRL:   rd_mux = {16'h0, bright, 7'h0, en};
      ADR_DPMASK: rd_mux = {24'h0, dpmask};
      default:    rd_mux = {24'h0, blank};
    endcase
  end

  // Read data is captured before any same-cycle write lands.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      o_wb_ack <= req;
      if (req) o_wb_rdt <= rd_mux;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre + 1'b1;
      if (&pre) idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end
  end

  // Narrow prescalers compare their full count so BRIGHT still sets duty.
  if (DIV_W >= 8) begin : g_level_top
    assign level = pre[DIV_W-1 -: 8];
  end else begin : g_level_full
    assign level = 8'(pre);
  end

  assign nibble = data[{idx, 2'b00} +: 4];
  assign lit    = en & ~blank[idx] & (level < bright);

  seg7_decode u_decode (
    .hex (nibble),
    .seg (seg)
  );

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      o_an <= '1;
      o_ca <= '1;
      o_dp <= 1'b1;
    end else if (lit) begin
      o_an <= ~(NUM_DIGITS'(1) << idx);
      o_ca <= seg;
      o_dp <= ~dpmask[idx];
    end else begin
      o_an <= '1;
      o_ca <= '1;
      o_dp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_sevenseg_ctrl.sv
// Bench for wb_sevenseg_ctrl: 8-digit and 3-digit instances on a shared bus,
// checked against a cycle-count based model of the scan and register file.
module tb_wb_sevenseg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [31:0] rdt8, rdt3;
  logic        ack8, ack3;
  logic [6:0]  ca8, ca3;
  logic        dp8, dp3;
  logic [7:0]  an8;
  logic [2:0]  an3;

  int vecs = 0;
  int errs = 0;
  int n;

  logic [31:0] m_data;
  logic        m_en;
  logic [7:0]  m_bright, m_dp, m_blank;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  wb_sevenseg_ctrl #(.NUM_DIGITS(8), .DIV_W(4)) dut8 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat),
    .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_rdt(rdt8), .o_wb_ack(ack8), .o_ca(ca8), .o_dp(dp8), .o_an(an8)
  );

  wb_sevenseg_ctrl #(.NUM_DIGITS(3), .DIV_W(4)) dut3 (
    .i_wb_clk(clk), .i_wb_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat),
    .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .o_wb_rdt(rdt3), .o_wb_ack(ack3), .o_ca(ca3), .o_dp(dp3), .o_an(an3)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'ha: return 7'h08; 4'hb: return 7'h03;
      4'hc: return 7'h46; 4'hd: return 7'h21; 4'he: return 7'h06; default: return 7'h0e;
    endcase
  endfunction

  // Pins after n edges show the scan position reached after n-1 edges.
  function automatic logic [15:0] pins_ref(input int nd);
    int s, pre, idx;
    logic [7:0] an;
    if (n == 0) return 16'hffff;
    s   = n - 1;
    pre = s % 16;
    idx = (s / 16) % nd;
    if (!(m_en && !m_blank[idx] && pre < int'(m_bright))) return 16'hffff;
    an = 8'hff;
    an[idx] = 1'b0;
    return {an, seg_ref(m_data[idx*4 +: 4]), ~m_dp[idx]};
  endfunction

  function automatic logic [31:0] read_ref(input logic [3:0] a, input int nd);
    logic [7:0] mask;
    mask = 8'((1 << nd) - 1);
    case (a[3:2])
      2'd0:    return m_data;
      2'd1:    return {16'h0, m_bright, 7'h0, m_en};
      2'd2:    return {24'h0, m_dp & mask};
      default: return {24'h0, m_blank & mask};
    endcase
  endfunction

  task automatic model_reset();
    m_data = '0; m_en = 1'b1; m_bright = 8'hff; m_dp = '0; m_blank = '0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[3:2])
      2'd0: for (int b = 0; b < 4; b++) if (s[b]) m_data[8*b +: 8] = d[8*b +: 8];
      2'd1: begin
        if (s[0]) m_en = d[0];
        if (s[1]) m_bright = d[15:8];
      end
      2'd2: if (s[0]) m_dp = d[7:0];
      default: if (s[0]) m_blank = d[7:0];
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_pins_idle(input string tag);
    chk({tag, "_pins8"}, {16'h0, an8, ca8, dp8}, 32'h0000ffff);
    chk({tag, "_pins3"}, {16'h0, 5'h1f, an3, ca3, dp3}, 32'h0000ffff);
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    adr = a; dat = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    chk("wr_ack_pre", {ack8, ack3}, 0);
    @(posedge clk); #1;
    chk("wr_ack", {ack8, ack3}, 32'h3);
    model_write(a, d, s);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("wr_ack_drop", {ack8, ack3}, 0);
  endtask

  task automatic wb_read(input logic [3:0] a);
    @(negedge clk);
    adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    chk("rd_ack_pre", {ack8, ack3}, 0);
    @(posedge clk); #1;
    chk("rd_ack", {ack8, ack3}, 32'h3);
    chk("rd_data8", rdt8, read_ref(a, 8));
    chk("rd_data3", rdt3, read_ref(a, 3));
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    chk("rd_ack_drop", {ack8, ack3}, 0);
  endtask

  task automatic scan(input int cycles);
    logic [15:0] e3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("scan8", {16'h0, an8, ca8, dp8}, {16'h0, pins_ref(8)});
      e3 = pins_ref(3);
      chk("scan3", {16'h0, 5'h1f, an3, ca3, dp3}, {16'h0, e3});
    end
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {ack8, ack3}, 0);
    chk("rst_rdt8", rdt8, 0);
    chk("rst_rdt3", rdt3, 0);
    check_pins_idle("rst");
    @(negedge clk);
    rst = 1'b0;

    wb_read(4'h0);
    wb_read(4'h4);
    wb_read(4'h8);
    wb_read(4'hc);

    wb_write(4'h0, 32'h76543210, 4'hf);
    scan(140);

    wb_write(4'h0, 32'h0, 4'hf);
    wb_write(4'h0, 32'h0000ab00, 4'b0010);
    wb_read(4'h0);
    chk("sel_lane", m_data, 32'h0000ab00);
    scan(40);

    wb_write(4'h4, 32'h00000401, 4'h3);
    scan(70);
    wb_write(4'h4, 32'h00000001, 4'h3);
    scan(40);

    wb_write(4'h4, 32'hffffffff, 4'hf);
    wb_read(4'h4);
    wb_write(4'h0, 32'h89abcdef, 4'hf);
    wb_write(4'hc, 32'h05, 4'h1);
    wb_write(4'h8, 32'h02, 4'h1);
    scan(140);

    wb_write(4'hc, 32'hff, 4'h1);
    wb_read(4'hc);
    wb_read(4'h8);
    wb_write(4'hc, 32'h00, 4'h1);

    for (int i = 0; i < 8; i++) begin
      wb_write(4'h0, $urandom, 4'hf);
      wb_write(4'h4, {16'h0, 8'($urandom), 7'h0, 1'($urandom_range(0, 3) != 0)}, 4'h3);
      wb_write(4'h8, $urandom, 4'h1);
      wb_write(4'hc, $urandom & $urandom, 4'h1);
      wb_write(4'($urandom_range(0, 3) << 2), $urandom, 4'($urandom));
      wb_read(4'($urandom_range(0, 15)));
      scan(60);
    end

    @(negedge clk);
    rst = 1'b1; adr = 4'h0; dat = 32'hdeadbeef; sel = 4'hf; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("rst_wr_ack", {ack8, ack3}, 0);
    check_pins_idle("rst_wr");
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wb_read(4'h0);
    wb_read(4'h4);
    wb_read(4'hc);
    scan(60);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/wb_sevenseg_ctrl.md
WB_SEVENSEG_CTRL -- requirements
Module: wb_sevenseg_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter DIV_W, default 15: width of the scan prescaler; one digit slot is 2^DIV_W cycles.
REQ-003 Port i_wb_clk, input, 1: single clock for the whole block.
REQ-004 Port i_wb_rst, input, 1: reset, synchronous to i_wb_clk and active-high.
REQ-005 Port i_wb_adr, input, 4: byte address; only [3:2] are decoded.
REQ-006 Ports i_wb_dat (input, 32), i_wb_sel (input, 4), i_wb_we (input, 1), i_wb_cyc (input, 1), i_wb_stb (input, 1): Wishbone slave request.
REQ-007 Ports o_wb_rdt (output, 32) and o_wb_ack (output, 1): Wishbone read data and acknowledge.
REQ-008 Port o_ca, output, 7: active-low segments a..g, with bit 0 = a.
REQ-009 Port o_dp, output, 1: active-low decimal point.
REQ-010 Port o_an, output, NUM_DIGITS: active-low digit enables.

Function
REQ-011 Register map:
- 0x0 DATA[31:0]: hex nibbles, digit k = bits [4k+3:4k].
- 0x4 CTRL: bit0 EN, bits[15:8] BRIGHT.
- 0x8 DPMASK[7:0]: per-digit decimal point, 1 = lit.
- 0xC BLANK[7:0]: per-digit blank, 1 = dark.
REQ-012 Register bits not listed in REQ-011 SHALL read 0, as SHALL mask bits at or above NUM_DIGITS.
REQ-013 Writes SHALL take effect only when cyc&stb&we&!o_wb_ack; each byte lane SHALL update only if its i_wb_sel bit is set.
REQ-014 o_wb_ack SHALL be registered as cyc&stb&!o_wb_ack, giving a one-cycle pulse, one cycle after the request, with at most one ack every two cycles.
REQ-015 o_wb_rdt SHALL be registered alongside o_wb_ack, holding the register at adr[3:2] as it was before any same-cycle write.
REQ-016 The prescaler SHALL count freely; at each wrap to 0, digit index idx SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-017 A digit SHALL be lit when EN=1, BLANK[idx]=0, and prescaler[DIV_W-1:DIV_W-8] < BRIGHT.
REQ-018 BRIGHT=0 SHALL give all digits off; BRIGHT=255 SHALL give 255/256 duty.
REQ-019 When a digit is lit:
- o_an SHALL have only bit idx low.
- o_ca SHALL be the decode of nibble idx.
- o_dp SHALL be ~DPMASK[idx].
REQ-020 When no digit is lit, o_an, o_ca and o_dp SHALL be all ones.
REQ-021 All display outputs SHALL be registered, with exactly one cycle of latency from the idx/prescaler/register state to the pins.
REQ-022 A register write SHALL be visible on the pins no later than 2 cycles after the write cycle; no glitch is permitted on digits other than the active one.
REQ-023 Hex decode SHALL use the standard active-low table: 0=1000000, 1=1111001, 8=0000000, F=0001110.
REQ-024 When NUM_DIGITS=1, idx SHALL remain 0.

Reset
REQ-025 On i_wb_rst:
- DATA=0, EN=1, BRIGHT=0xFF, DPMASK=0, BLANK=0.
- prescaler=0, idx=0.
- o_wb_ack=0, o_wb_rdt=0.
- o_an, o_ca and o_dp all ones.
REQ-026 A reset asserted during a Wishbone cycle SHALL suppress the ack; the interrupted write SHALL be lost, and the master retries.
REQ-027 Reset SHALL take priority over any simultaneous write.

Structure
REQ-028 Package wb_sevenseg_pkg SHALL hold the register offset constants, the CTRL field positions and reset values, and the 16-entry segment table.
REQ-029 The block SHALL use one sub-module, seg7_decode (4-bit hex in, 7-bit active-low out, purely combinational), instantiated once.

Verification
REQ-030 The bench SHALL cover these directed scenarios, all with DIV_W=4 unless stated:
- Reset, then write DATA=0x76543210 -> digit k shows k in scan order 0..7; o_an walks 11111110, 11111101, and so on, changing every 16 cycles.
- Write DATA with sel=0b0010 and dat=0xAB00 -> only bits[15:8]=0xAB; readback returns 0x0000AB00 with ack exactly 1 cycle after stb.
- CTRL.BRIGHT=0x04 -> each 16-cycle slot has an active o_an low for exactly 4 cycles; BRIGHT=0 -> o_an stays all ones.
- BLANK=0x05 and DPMASK=0x02 -> digits 0 and 2 are never enabled; o_dp is low only while idx=1.
- NUM_DIGITS=3 -> idx wraps 2->0; a read of BLANK after writing 0xFF returns 0x07; reads of unmapped CTRL bits return 0.
- Reset asserted mid-scan on the cycle a write is presented -> no ack, registers at reset values, outputs all ones on the next cycle.
